// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Key table entries are {ext, code}
    localparam logic [8:0] KEY_A     = 9'h01C;
    localparam logic [8:0] KEY_D     = 9'h023;
    localparam logic [8:0] KEY_W     = 9'h01D;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_DOWN  = 9'h172;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - pin glitch filter, 11-bit frame FSM and inter-edge timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [FILTER_LEN-1:0] clk_sr;
    logic [FILTER_LEN-1:0] data_sr;
    logic [FILTER_LEN-1:0] clk_sr_nxt;
    logic [FILTER_LEN-1:0] data_sr_nxt;
    logic                  clk_f;
    logic                  clk_f_d;
    logic                  data_f;
    logic                  fall;

    assign clk_sr_nxt  = {clk_sr[FILTER_LEN-2:0], ps2_clk};
    assign data_sr_nxt = {data_sr[FILTER_LEN-2:0], ps2_data};

    // Filtered levels follow the shift register's next value so a level
    // change lands on the same edge the register becomes unanimous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr  <= '1;
            data_sr <= '1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            data_f  <= 1'b1;
        end else begin
            clk_sr  <= clk_sr_nxt;
            data_sr <= data_sr_nxt;
            clk_f_d <= clk_f;
            if (&clk_sr_nxt) begin
                clk_f <= 1'b1;
            end else if (~|clk_sr_nxt) begin
                clk_f <= 1'b0;
            end
            if (&data_sr_nxt) begin
                data_f <= 1'b1;
            end else if (~|data_sr_nxt) begin
                data_f <= 1'b0;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    frame_state_t  state;
    frame_state_t  state_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          par_q;
    logic          par_nxt;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    assign timeout = (state != IDLE) && (to_cnt == TO_LAST);
    assign rx_byte = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par_q   <= par_nxt;
            if (fall) begin
                to_cnt <= '0;
            end else if ((state != IDLE) && (to_cnt != '1)) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Timeout has priority over a coincident fall strobe.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par_q;
        byte_rdy    = 1'b0;
        frame_err   = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            frame_err = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_f) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nxt   = {data_f, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt   = data_f;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (data_f && odd_parity_ok(shreg, par_q)) begin
                        byte_rdy = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keys_rx.sv
// rtl/ps2_keys_rx.sv - PS/2 keyboard receiver: E0/F0 prefix decoder and held-key table
module ps2_keys_rx
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS    = 4,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES   = {KEY_A, KEY_D, KEY_W, KEY_SPACE},
    parameter int                    FILTER_LEN  = 8,
    parameter int                    TIMEOUT_CYC = 200000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] keys,
    output logic                scan_valid,
    output logic [7:0]          scan_code,
    output logic                scan_ext,
    output logic                scan_brk,
    output logic                frame_err
);

    logic       byte_rdy;
    logic [7:0] rx_byte;
    logic       err_w;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_rdy (byte_rdy),
        .rx_byte  (rx_byte),
        .frame_err(err_w)
    );

    logic                ext_q;
    logic                brk_q;
    logic [NUM_KEYS-1:0] key_hit;

    always_comb begin
        key_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_hit[i] = ({ext_q, rx_byte} == KEY_CODES[9*i +: 9]);
        end
    end

    // A bad frame drops any pending prefix so it cannot attach to a later code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys       <= '0;
            scan_valid <= 1'b0;
            scan_code  <= 8'd0;
            scan_ext   <= 1'b0;
            scan_brk   <= 1'b0;
            frame_err  <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= err_w;
            if (err_w) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_rdy) begin
                if (rx_byte == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    scan_valid <= 1'b1;
                    scan_code  <= rx_byte;
                    scan_ext   <= ext_q;
                    scan_brk   <= brk_q;
                    ext_q      <= 1'b0;
                    brk_q      <= 1'b0;
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (key_hit[i]) begin
                            keys[i] <= ~brk_q;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keys_rx.sv
// tb/tb_ps2_keys_rx.sv - self-checking bench for ps2_keys_rx
module tb_ps2_keys_rx;

    localparam int FL   = 4;
    localparam int TC   = 64;
    localparam int NK   = 4;
    localparam int HALF = 4;
    localparam int LOW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic [NK-1:0] keys;
    logic          scan_valid;
    logic [7:0]    scan_code;
    logic          scan_ext;
    logic          scan_brk;
    logic          frame_err;

    ps2_keys_rx #(
        .NUM_KEYS   (NK),
        .KEY_CODES  ({9'h01C, 9'h023, 9'h01D, 9'h029}),
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keys      (keys),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .scan_ext  (scan_ext),
        .scan_brk  (scan_brk),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            sv_cnt = 0;
    int            err_cnt = 0;
    int            sv_cyc = -1;
    int            err_cyc = -1;
    logic [NK-1:0] sv_keys = '0;
    always @(negedge clk) begin
        if (scan_valid) begin
            sv_cnt++;
            sv_cyc  = cyc;
            sv_keys = keys;
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: key table, pending prefixes and expected observable state
    logic [8:0]    ktab [NK];
    logic [NK-1:0] m_keys = '0;
    logic          m_ext = 1'b0;
    logic          m_brk = 1'b0;
    int            m_sv = 0;
    int            m_err = 0;
    logic [7:0]    m_code = 8'd0;
    logic          m_sext = 1'b0;
    logic          m_sbrk = 1'b0;

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m_sv++;
            m_code = b;
            m_sext = m_ext;
            m_sbrk = m_brk;
            for (int i = 0; i < NK; i++)
                if (ktab[i] == {m_ext, b}) m_keys[i] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".events"}, sv_cnt, m_sv);
        chk({tag, ".errors"}, err_cnt, m_err);
        chk({tag, ".keys"}, 32'(keys), 32'(m_keys));
        chk({tag, ".code"}, 32'(scan_code), 32'(m_code));
        chk({tag, ".ext"}, 32'(scan_ext), 32'(m_sext));
        chk({tag, ".brk"}, 32'(scan_brk), 32'(m_sbrk));
    endtask

    int last_fall_cyc = 0;

    task automatic clk_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (LOW) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        clk_bit(1'b0);
        for (int i = 0; i < 8; i++) clk_bit(b[i]);
        clk_bit((~^b) ^ bad_par);
        clk_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input logic bad_par,
                            input logic bad_stop);
        send_frame(b, bad_par, bad_stop);
        model_frame(b, !(bad_par || bad_stop));
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool [7];
        int         t_err0;
        int         t_sv0;
        int         to_fall;
        logic [7:0] rb;
        logic       bp;
        logic       bs;

        ktab[3] = 9'h01C;
        ktab[2] = 9'h023;
        ktab[1] = 9'h01D;
        ktab[0] = 9'h029;

        repeat (3) @(negedge clk);
        chk("reset.keys", 32'(keys), 32'h0);
        chk("reset.scan_valid", 32'(scan_valid), 32'h0);
        chk("reset.code", 32'(scan_code), 32'h0);
        chk("reset.ext_brk", 32'({scan_ext, scan_brk}), 32'h0);
        chk("reset.frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_frame("press_a", 8'h1C, 1'b0, 1'b0);
        chk("press_a.latency", sv_cyc, last_fall_cyc + FL + 1);
        chk("press_a.keys_at_event", 32'(sv_keys), 32'b1000);

        do_frame("brk_prefix", 8'hF0, 1'b0, 1'b0);
        do_frame("release_a", 8'h1C, 1'b0, 1'b0);

        do_frame("press_w", 8'h1D, 1'b0, 1'b0);
        do_frame("ext_prefix", 8'hE0, 1'b0, 1'b0);
        do_frame("ext_1d", 8'h1D, 1'b0, 1'b0);

        do_frame("space_badpar", 8'h29, 1'b1, 1'b0);
        chk("space_badpar.err_latency", err_cyc, last_fall_cyc + FL + 1);
        do_frame("space_good", 8'h29, 1'b0, 1'b0);

        do_frame("w_brk", 8'hF0, 1'b0, 1'b0);
        do_frame("w_release", 8'h1D, 1'b0, 1'b0);
        do_frame("pre_to_ext", 8'hE0, 1'b0, 1'b0);
        t_err0 = err_cnt;
        t_sv0  = sv_cnt;
        clk_bit(1'b0);
        for (int i = 0; i < 5; i++) clk_bit(1'($urandom_range(0, 1)));
        to_fall = last_fall_cyc;
        for (int n = 0; n < TC + 40 && err_cnt == t_err0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        model_frame(8'h00, 1'b0);
        chk("timeout.err_count", err_cnt, t_err0 + 1);
        chk("timeout.latency", err_cyc, to_fall + FL + 1 + TC);
        chk("timeout.no_event", sv_cnt, t_sv0);
        do_frame("after_timeout_w", 8'h1D, 1'b0, 1'b0);

        ps2_data = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check_state("glitch");
        do_frame("after_glitch_d", 8'h23, 1'b0, 1'b0);

        do_frame("pre_reset_ext", 8'hE0, 1'b0, 1'b0);
        clk_bit(1'b0);
        for (int i = 0; i < 3; i++) clk_bit(1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.keys", 32'(keys), 32'h0);
        chk("midreset.outputs", 32'({scan_valid, scan_ext, scan_brk, frame_err}), 32'h0);
        chk("midreset.code", 32'(scan_code), 32'h0);
        m_keys = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_code = 8'd0;
        m_sext = 1'b0;
        m_sbrk = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_frame("after_reset_w", 8'h1D, 1'b0, 1'b0);

        pool[0] = 8'hE0;
        pool[1] = 8'hF0;
        pool[2] = 8'h1C;
        pool[3] = 8'h23;
        pool[4] = 8'h1D;
        pool[5] = 8'h29;
        pool[6] = 8'hAA;
        for (int n = 0; n < 40; n++) begin
            rb = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 6)];
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 11) == 0);
            do_frame($sformatf("rand%0d", n), rb, bp, bs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
